// File: rtl/vector_lane_serializer_if.sv
// Handshake bundle for vector_lane_serializer.
//   Input side : in_valid/in_ready with in_vec (VECTOR_WIDTH lanes of WIDTH bits)
//                and in_mask (one bit per lane).
//   Output side: out_valid/out_ready with out_data, out_lane, out_last.
//   Status     : busy.
// master = the producer/consumer environment, slave = the serializer.
interface vector_lane_serializer_if #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8
);
  localparam int LW = $clog2(VECTOR_WIDTH);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   in_vec;
  logic [VECTOR_WIDTH-1:0]              in_mask;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [WIDTH-1:0]                     out_data;
  logic [LW-1:0]                        out_lane;
  logic                                 out_last;
  logic                                 busy;

  modport master (
    output in_valid, in_vec, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, busy
  );

  modport slave (
    input  in_valid, in_vec, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, busy
  );
endinterface

// File: rtl/vector_lane_serializer.sv
// Captures a whole vector in one input handshake, then emits its active lanes
// (mask bit set) one per output handshake in ascending lane order. Each beat
// carries the lane value, its index and a flag marking the highest active lane.
// Ports:
//   clk   - clock, rising edge.
//   reset - synchronous, active-high; also forces all outputs to 0 while high.
//   bus   - vector_lane_serializer_if slave: input vector stream, scalar output
//           stream and busy status.
module vector_lane_serializer #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  vector_lane_serializer_if.slave bus
);
  localparam int LW = $clog2(VECTOR_WIDTH);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                              state_q, state_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  vec_q, vec_d;
  logic [VECTOR_WIDTH-1:0]             mask_q, mask_d;
  logic [LW-1:0]                       ptr_q, ptr_d;

  logic [LW-1:0] first_lane;
  logic [LW-1:0] next_lane;
  logic          has_next;
  logic          streaming;
  logic          in_hs;
  logic          out_hs;

  // Lowest set bit of the incoming mask; scanning downward lets the last hit win.
  always_comb begin
    first_lane = '0;
    for (int i = VECTOR_WIDTH - 1; i >= 0; i--) begin
      if (bus.in_mask[i]) first_lane = LW'(i);
    end
  end

  // Next set bit strictly above ptr; no wrap, so the top lane is always terminal.
  always_comb begin
    has_next  = 1'b0;
    next_lane = '0;
    for (int i = VECTOR_WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ptr_q))) begin
        has_next  = 1'b1;
        next_lane = LW'(i);
      end
    end
  end

  // Outputs are gated by reset so an aborted stream disappears immediately.
  assign streaming    = (state_q == StStream) && !reset;
  assign bus.in_ready = (state_q == StIdle) && !reset;
  assign bus.out_valid = streaming;
  assign bus.out_data  = streaming ? vec_q[ptr_q] : '0;
  assign bus.out_lane  = streaming ? ptr_q : '0;
  assign bus.out_last  = streaming && !has_next;
  assign bus.busy      = streaming;

  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = streaming && bus.out_ready;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          vec_d  = bus.in_vec;
          mask_d = bus.in_mask;
          ptr_d  = first_lane;
          // An empty mask is consumed silently.
          if (|bus.in_mask) state_d = StStream;
        end
      end
      StStream: begin
        if (out_hs) begin
          if (has_next) ptr_d = next_lane;
          else          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_vector_lane_serializer.sv
module tb_vector_lane_serializer;
  localparam int WIDTH = 24;
  localparam int VW    = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  vector_lane_serializer_if #(.WIDTH(WIDTH), .VECTOR_WIDTH(VW)) bus ();

  vector_lane_serializer #(.WIDTH(WIDTH), .VECTOR_WIDTH(VW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, out_lane, out_last, out_data}
  function automatic logic [28:0] obs_beat();
    return {bus.out_valid, bus.out_lane, bus.out_last, bus.out_data};
  endfunction

  task automatic test_reset();
    logic [VW-1:0][WIDTH-1:0] v;
    for (int i = 0; i < VW; i++) v[i] = WIDTH'(24'h500 + i);
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_vec = v; bus.in_mask = 8'hFF;
    bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.out_last});
    end
    checks++;
    if ({bus.out_lane, bus.out_data} !== 27'd0) begin
      errors++;
      $display("FAIL reset_data: got lane=%0d data=%h want 0/0", bus.out_lane, bus.out_data);
    end
    reset = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got rdy/vld/busy=%b want 100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
  endtask

  task automatic test_full_mask();
    logic [VW-1:0][WIDTH-1:0] v;
    logic [28:0] exp;
    for (int i = 0; i < VW; i++) v[i] = WIDTH'(24'h10 + i);
    bus.in_vec = v; bus.in_mask = 8'hFF; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < VW; i++) begin
      exp = {1'b1, 3'(i), (i == 7), v[i]};
      checks++;
      if (obs_beat() !== exp) begin
        errors++;
        $display("FAIL full_beat%0d: got %h want %h", i, obs_beat(), exp);
      end
      if (i == 0) begin
        checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
          errors++;
          $display("FAIL full_busy: got busy/rdy=%b want 10", {bus.busy, bus.in_ready});
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      errors++;
      $display("FAIL full_done: got vld/rdy/busy=%b want 010",
               {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_sparse_mask();
    logic [VW-1:0][WIDTH-1:0] v;
    logic [28:0] exp;
    int lanes[3] = '{2, 5, 7};
    for (int i = 0; i < VW; i++) v[i] = WIDTH'(24'hA00000 + 24'h111 * i);
    bus.in_vec = v; bus.in_mask = 8'b1010_0100; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = {1'b1, 3'(lanes[k]), (k == 2), v[lanes[k]]};
      checks++;
      if (obs_beat() !== exp) begin
        errors++;
        $display("FAIL sparse_beat%0d: got %h want %h", k, obs_beat(), exp);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sparse_done: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0][WIDTH-1:0] v;
    logic [28:0] exp;
    for (int i = 0; i < VW; i++) v[i] = WIDTH'(24'hBEEF00 + i);
    bus.in_vec = v; bus.in_mask = 8'h03; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, 3'd0, 1'b0, v[0]};
      checks++;
      if (obs_beat() !== exp) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", k, obs_beat(), exp);
      end
      bus.out_ready = (k == 3);
      @(negedge clk);
    end
    exp = {1'b1, 3'd1, 1'b1, v[1]};
    checks++;
    if (obs_beat() !== exp) begin
      errors++;
      $display("FAIL bp_lane1: got %h want %h", obs_beat(), exp);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_zero_mask();
    bus.in_vec = '1; bus.in_mask = 8'h00; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL zero_mask%0d: got vld/busy/rdy=%b want 001", k,
                 {bus.out_valid, bus.busy, bus.in_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    logic [VW-1:0][WIDTH-1:0] v;
    logic [28:0] exp;
    for (int i = 0; i < VW; i++) v[i] = WIDTH'(24'h300 + i);
    bus.in_vec = v; bus.in_mask = 8'hFF; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 3'(i), 1'b0, v[i]};
      checks++;
      if (obs_beat() !== exp) begin
        errors++;
        $display("FAIL rst_beat%0d: got %h want %h", i, obs_beat(), exp);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({obs_beat(), bus.in_ready, bus.busy} !== 31'd0) begin
      errors++;
      $display("FAIL rst_outputs: got beat=%h rdy=%b busy=%b want all 0",
               obs_beat(), bus.in_ready, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release: got rdy/vld=%b want 10", {bus.in_ready, bus.out_valid});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_resume%0d: got out_valid=%b lane=%0d want 0", k,
                 bus.out_valid, bus.out_lane);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0][WIDTH-1:0] va;
    logic [VW-1:0][WIDTH-1:0] vb;
    logic [28:0] exp;
    for (int i = 0; i < VW; i++) begin
      va[i] = WIDTH'(24'hA0A000 + i);
      vb[i] = WIDTH'(24'hB0B000 + i);
    end
    bus.in_vec = va; bus.in_mask = 8'h81; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    // Second vector offered while the first is still draining.
    bus.in_vec = vb; bus.in_mask = 8'h10;
    exp = {1'b1, 3'd0, 1'b0, va[0]};
    checks++;
    if (obs_beat() !== exp) begin
      errors++;
      $display("FAIL b2b_a_lane0: got %h want %h", obs_beat(), exp);
    end
    @(negedge clk);
    exp = {1'b1, 3'd7, 1'b1, va[7]};
    checks++;
    if (obs_beat() !== exp) begin
      errors++;
      $display("FAIL b2b_a_lane7: got %h want %h", obs_beat(), exp);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: got vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = {1'b1, 3'd4, 1'b1, vb[4]};
    checks++;
    if (obs_beat() !== exp) begin
      errors++;
      $display("FAIL b2b_b_lane4: got %h want %h", obs_beat(), exp);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: got vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    bus.in_mask = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_backpressure();
    test_zero_mask();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_lane_serializer.md
# vector_lane_serializer

Drains a captured vector register value one lane at a time onto a scalar valid/ready stream. Lanes whose mask bit is clear are skipped. The block is the read-out end of the vector pipeline-register path: a full `VECTOR_WIDTH x WIDTH` vector is taken in one handshake and handed to scalar consumers such as the memory store port or debug output. The consumer sees each active lane with its index and a last-lane flag.

## Interface
- `WIDTH`, default 24: bits per lane element.
- `VECTOR_WIDTH`, default 8: lanes per vector, power of two, at least 2.
- `LW`, derived as `$clog2(VECTOR_WIDTH)`: lane index width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  vector offered.
- `in_ready`  out  1  block can capture a vector.
- `in_vec`  in  `[VECTOR_WIDTH-1:0][WIDTH-1:0]`  vector; lane i is `in_vec[i]`.
- `in_mask`  in  `VECTOR_WIDTH`  active-lane mask; bit i set means lane i is emitted.
- `out_valid`  out  1  scalar element valid.
- `out_ready`  in  1  consumer accepts element.
- `out_data`  out  `WIDTH`  element value.
- `out_lane`  out  `LW`  lane index of `out_data`.
- `out_last`  out  1  this is the highest active lane of the vector.
- `busy`  out  1  a vector is held and not yet fully drained.

## Operation
- Two-state FSM: IDLE and STREAM.
- `in_ready = (state == IDLE) && !reset`.
- Input handshake occurs when `in_valid && in_ready` at a rising edge.
- On the input handshake, `in_vec` is copied to the internal `vec_q` and `in_mask` to `mask_q`.
- If `in_mask == 0`, the vector is consumed with no output and the FSM stays in IDLE.
- If `in_mask != 0`, the FSM moves to STREAM and `ptr` is set to the lowest set bit of `in_mask`.
- In STREAM:
  - `out_valid = 1`, `out_data = vec_q[ptr]`, `out_lane = ptr`.
  - `out_last = 1` when no bit of `mask_q` above `ptr` is set.
- Output handshake occurs when `out_valid && out_ready`.
  - If `out_last` is clear, `ptr` moves to the next higher set bit of `mask_q`.
  - If `out_last` is set, the FSM returns to IDLE.
- Lanes are emitted in ascending index order. Each active lane is emitted exactly once; masked lanes are never emitted.
- In IDLE: `out_valid = 0`, and `out_data`, `out_lane` and `out_last` are driven to 0.
- `busy = (state == STREAM)`.
- Next-set-bit search is a combinational priority encoder over `mask_q` bits above `ptr`. There is no wrap-around: lane `VECTOR_WIDTH-1` is always terminal.
- Masked-off lanes are held in `vec_q` but never appear on `out_data`.

## Timing
- Reset values: state IDLE, `vec_q` 0, `mask_q` 0, `ptr` 0.
- Outputs during reset: `out_valid` 0, `out_data` 0, `out_lane` 0, `out_last` 0, `busy` 0, `in_ready` 0.
- Reset asserted mid-stream aborts the vector. Remaining lanes are discarded; none are emitted after reset releases.
- Latency: the first element is valid in the cycle after the input handshake.
- Throughput: N active lanes give N consecutive beats when `out_ready` is held high.
- One IDLE cycle separates vectors. The next vector's input handshake is in the cycle after the last beat. A vector with N active lanes occupies N+1 cycles.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_lane` and `out_last` hold stable and `ptr` does not advance.
- `in_vec` and `in_mask` are ignored whenever `in_ready` is 0. Changes to them during STREAM do not affect the vector in flight.
- Simultaneous `reset` and `in_valid`: no capture, and the block stays IDLE.

## Test plan
- Full mask streaming:
  - Stimulus: `in_vec` lanes 0..7 = 0x000010..0x000017, `in_mask` = 8'hFF, `out_ready` = 1.
  - Response: 8 consecutive beats with lanes 0..7 and data 0x10..0x17; `out_last` only on lane 7; `in_ready` returns the cycle after.
- Sparse mask:
  - Stimulus: `in_mask` = 8'b1010_0100.
  - Response: exactly three beats, lanes 2, 5, 7 with their data; `out_last` only on lane 7.
- Backpressure:
  - Stimulus: mask 8'h03; `out_ready` low for 3 cycles on lane 0, then high.
  - Response: lane 0 data stable for 4 cycles; lane 1 follows the next cycle with `out_last` = 1.
- Zero mask:
  - Stimulus: handshake with `in_mask` = 0.
  - Response: `out_valid` never rises, `busy` stays 0, `in_ready` remains 1 next cycle.
- Reset mid-stream:
  - Stimulus: mask 8'hFF; assert `reset` after lane 3 is accepted.
  - Response: `out_valid` drops with `reset`; all outputs are 0; no lanes 4..7 appear after release; `in_ready` is 1 one cycle after release.
- Back-to-back vectors:
  - Stimulus: `in_valid` held high with two vectors (masks 8'h81 then 8'h10).
  - Response: beats lane 0, lane 7 (last), one idle cycle, then lane 4 (last).
